// File: rtl/fracnet_mac_pkg.sv
// Shared types and helpers for the FracNet multi-lane MAC pipeline:
// product width/signedness, operand/product extension, saturation limits
// and the per-beat sideband carried alongside the data.
package fracnet_mac_pkg;

   // Widest value the extension/limit helpers handle (ACC_W must not exceed it).
   localparam int MAX_W = 64;

   // Group delimiters that travel with every beat.
   typedef struct packed {
      logic first;
      logic last;
   } beat_side_t;

   // Full-precision product width.
   function automatic int prod_w(input int a_w, input int b_w);
      return a_w + b_w;
   endfunction

   // The product (and hence the accumulator) is signed if either operand is.
   function automatic bit prod_signed(input bit a_s, input bit b_s);
      return a_s || b_s;
   endfunction

   // Extend the low w bits of v to MAX_W bits, sign- or zero-filling.
   function automatic logic [MAX_W-1:0] ext_val(input logic [MAX_W-1:0] v,
                                                input int w, input bit sgn);
      int                       sh;
      logic signed [MAX_W-1:0]  t;
      logic [MAX_W-1:0]         r;
      sh = MAX_W - w;
      t  = v << sh;
      if (sgn)
         r = t >>> sh;
      else
         r = (v << sh) >> sh;
      return r;
   endfunction

   // Largest accumulator value for the given width and signedness.
   function automatic logic [MAX_W-1:0] sat_hi(input int acc_w, input bit sgn);
      logic [MAX_W-1:0] r;
      if (sgn)
         r = (MAX_W'(1) << (acc_w - 1)) - MAX_W'(1);
      else
         r = (MAX_W'(1) << acc_w) - MAX_W'(1);
      return r;
   endfunction

   // Smallest accumulator value (two's complement pattern, low acc_w bits).
   function automatic logic [MAX_W-1:0] sat_lo(input int acc_w, input bit sgn);
      logic [MAX_W-1:0] r;
      if (sgn)
         r = MAX_W'(1) << (acc_w - 1);
      else
         r = '0;
      return r;
   endfunction

endpackage

// File: rtl/fracnet_mac_pipe_if.sv
// Beat-in / result-out handshake bundle of the FracNet MAC pipeline.
// master = upstream/downstream environment, slave = the MAC engine.
interface fracnet_mac_pipe_if #(
   parameter int LANES = 4,
   parameter int A_W   = 8,
   parameter int B_W   = 11,
   parameter int ACC_W = 32
) ();
   logic                   in_valid;
   logic                   in_ready;
   logic [LANES*A_W-1:0]   in_a;
   logic [LANES*B_W-1:0]   in_b;
   logic                   in_first;
   logic                   in_last;
   logic                   out_valid;
   logic                   out_ready;
   logic [LANES*ACC_W-1:0] out_acc;

   modport master (
      output in_valid, in_a, in_b, in_first, in_last, out_ready,
      input  in_ready, out_valid, out_acc
   );

   modport slave (
      input  in_valid, in_a, in_b, in_first, in_last, out_ready,
      output in_ready, out_valid, out_acc
   );
endinterface

// File: rtl/fracnet_mac_lane.sv
// One MAC lane: operand extension, multiply, STAGES-deep product pipeline
// and the group accumulator. The whole lane freezes when en is low.
// Optional feature: FRACNET_MAC_SAT_EN makes the accumulate add saturate
// instead of wrapping modulo 2^ACC_W.
module fracnet_mac_lane
   import fracnet_mac_pkg::*;
#(
   parameter int A_W      = 8,
   parameter int B_W      = 11,
   parameter int ACC_W    = 32,
   parameter int STAGES   = 3,
   parameter int A_SIGNED = 0,
   parameter int B_SIGNED = 0
) (
   input  logic             ap_clk,
   input  logic             ap_rst_n,
   input  logic             en,        // pipeline advances this cycle
   input  logic [A_W-1:0]   a,
   input  logic [B_W-1:0]   b,
   input  logic             acc_en,    // valid beat leaves the product pipe
   input  logic             acc_init,  // start a fresh sum with this product
   output logic [ACC_W-1:0] acc_next   // value the accumulator takes on acc_en
);
   localparam int PW   = prod_w(A_W, B_W);
   localparam bit PSGN = prod_signed(A_SIGNED != 0, B_SIGNED != 0);

   logic [PW-1:0]    a_x;
   logic [PW-1:0]    b_x;
   logic [PW-1:0]    p_mult;
   logic [PW-1:0]    p_pipe_reg [STAGES];
   logic [ACC_W-1:0] acc_reg;
   logic [ACC_W-1:0] p_ext;
   logic [ACC_W-1:0] base;
`ifdef FRACNET_MAC_SAT_EN
   localparam logic [ACC_W-1:0] SAT_HI = ACC_W'(sat_hi(ACC_W, PSGN));
   localparam logic [ACC_W-1:0] SAT_LO = ACC_W'(sat_lo(ACC_W, PSGN));
   logic [ACC_W:0]   sum_w;
`endif

   // Extend both operands to product width; the low PW bits of a PW x PW
   // multiply are exact for any signed/unsigned mix.
   always_comb begin
      a_x    = PW'(ext_val(MAX_W'(a), A_W, A_SIGNED != 0));
      b_x    = PW'(ext_val(MAX_W'(b), B_W, B_SIGNED != 0));
      p_mult = a_x * b_x;
   end

   // Product delay line; registers behind the multiplier are free for retiming.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         for (int i = 0; i < STAGES; i++) p_pipe_reg[i] <= '0;
      end else if (en) begin
         p_pipe_reg[0] <= p_mult;
         for (int i = 1; i < STAGES; i++) p_pipe_reg[i] <= p_pipe_reg[i-1];
      end
   end

   // Extend the product to accumulator width and form the new running sum.
   always_comb begin
      p_ext = ACC_W'(ext_val(MAX_W'(p_pipe_reg[STAGES-1]), PW, PSGN));
      base  = acc_init ? '0 : acc_reg;
`ifdef FRACNET_MAC_SAT_EN
      if (PSGN)
         sum_w = {base[ACC_W-1], base} + {p_ext[ACC_W-1], p_ext};
      else
         sum_w = {1'b0, base} + {1'b0, p_ext};
      acc_next = sum_w[ACC_W-1:0];
      if (PSGN) begin
         // Overflow shows up as disagreement between the guard and sign bits.
         if (sum_w[ACC_W] != sum_w[ACC_W-1])
            acc_next = sum_w[ACC_W] ? SAT_LO : SAT_HI;
      end else if (sum_w[ACC_W]) begin
         acc_next = SAT_HI;
      end
`else
      acc_next = base + p_ext;
`endif
   end

   // Accumulator register, updated only when a valid beat is consumed.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n)
         acc_reg <= '0;
      else if (acc_en)
         acc_reg <= acc_next;
   end

endmodule

// File: rtl/fracnet_mac_pipe.sv
// FracNet pipelined multi-lane multiply-accumulate engine.
// LANES lanes multiply per beat, accumulate over first..last groups and emit
// one result vector per group. Backpressure is a global stall of the whole
// pipe. Optional feature: FRACNET_MAC_SAT_EN (saturating accumulate).
module fracnet_mac_pipe
   import fracnet_mac_pkg::*;
#(
   parameter int LANES    = 4,
   parameter int A_W      = 8,
   parameter int B_W      = 11,
   parameter int ACC_W    = 32,
   parameter int STAGES   = 3,
   parameter int A_SIGNED = 0,
   parameter int B_SIGNED = 0
) (
   input logic               ap_clk,
   input logic               ap_rst_n,
   fracnet_mac_pipe_if.slave bus
);
   logic                   stall;
   logic                   en;
   logic                   acc_en;
   logic                   acc_init;
   logic                   ld_out;
   beat_side_t             in_side;
   logic                   vld_reg  [STAGES];
   beat_side_t             side_reg [STAGES];
   logic                   expect_first_reg;
   logic                   out_valid_reg;
   logic [LANES*ACC_W-1:0] out_acc_reg;
   logic [LANES*ACC_W-1:0] acc_next_all;

   // Stall whenever a result is held unaccepted; beats at the accumulate
   // stage are consumed only while the pipe moves.
   always_comb begin
      stall         = out_valid_reg && !bus.out_ready;
      en            = !stall;
      in_side.first = bus.in_first;
      in_side.last  = bus.in_last;
      acc_en        = en && vld_reg[STAGES-1];
      acc_init      = side_reg[STAGES-1].first || expect_first_reg;
      ld_out        = acc_en && side_reg[STAGES-1].last;
   end

   assign bus.in_ready  = en;
   assign bus.out_valid = out_valid_reg;
   assign bus.out_acc   = out_acc_reg;

   // Valid/sideband shift register aligned with the lanes' product pipes.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            vld_reg[i]  <= 1'b0;
            side_reg[i] <= '0;
         end
      end else if (en) begin
         vld_reg[0]  <= bus.in_valid;
         side_reg[0] <= in_side;
         for (int i = 1; i < STAGES; i++) begin
            vld_reg[i]  <= vld_reg[i-1];
            side_reg[i] <= side_reg[i-1];
         end
      end
   end

   // Group state: the beat after a last (or after reset) restarts the sum.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n)
         expect_first_reg <= 1'b1;
      else if (acc_en)
         expect_first_reg <= side_reg[STAGES-1].last;
   end

   // Output register: loads on a last beat, clears once accepted, holds on stall.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         out_valid_reg <= 1'b0;
         out_acc_reg   <= '0;
      end else if (en) begin
         out_valid_reg <= ld_out;
         if (ld_out) out_acc_reg <= acc_next_all;
      end
   end

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         fracnet_mac_lane #(
            .A_W      (A_W),
            .B_W      (B_W),
            .ACC_W    (ACC_W),
            .STAGES   (STAGES),
            .A_SIGNED (A_SIGNED),
            .B_SIGNED (B_SIGNED)
         ) u_lane (
            .ap_clk   (ap_clk),
            .ap_rst_n (ap_rst_n),
            .en       (en),
            .a        (bus.in_a[gi*A_W +: A_W]),
            .b        (bus.in_b[gi*B_W +: B_W]),
            .acc_en   (acc_en),
            .acc_init (acc_init),
            .acc_next (acc_next_all[gi*ACC_W +: ACC_W])
         );
      end
   endgenerate

endmodule

// File: tb/tb_fracnet_mac_pipe.sv
// Self-checking bench for fracnet_mac_pipe: table of beats with a result
// scoreboard on the default unsigned instance, plus short sequences on a
// signed instance and a narrow-accumulator instance.
module tb_fracnet_mac_pipe;
   localparam int LANES  = 4;
   localparam int A_W    = 8;
   localparam int B_W    = 11;
   localparam int ACC_W  = 32;
   localparam int STAGES = 3;
   localparam int NW     = 20;
   localparam int NROWS  = 14;

   typedef struct packed {
      logic [LANES*A_W-1:0]   a;
      logic [LANES*B_W-1:0]   b;
      logic                   first;
      logic                   last;
      logic [LANES*ACC_W-1:0] exp;
   } vec_t;

   typedef struct {
      logic [LANES*ACC_W-1:0] exp;
      int                     t;
      bit                     lat;
   } sb_t;

   logic ap_clk = 1'b0;
   logic ap_rst_n = 1'b0;
   always #5 ap_clk = ~ap_clk;

   int cyc = 0;
   always @(posedge ap_clk) cyc <= cyc + 1;

   fracnet_mac_pipe_if #(.LANES(LANES), .A_W(A_W), .B_W(B_W), .ACC_W(ACC_W)) bus   ();
   fracnet_mac_pipe_if #(.LANES(LANES), .A_W(A_W), .B_W(B_W), .ACC_W(ACC_W)) bus_s ();
   fracnet_mac_pipe_if #(.LANES(LANES), .A_W(A_W), .B_W(B_W), .ACC_W(NW))    bus_w ();

   fracnet_mac_pipe #(.LANES(LANES), .A_W(A_W), .B_W(B_W), .ACC_W(ACC_W),
                      .STAGES(STAGES), .A_SIGNED(0), .B_SIGNED(0))
      u_dut (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(bus));

   fracnet_mac_pipe #(.LANES(LANES), .A_W(A_W), .B_W(B_W), .ACC_W(ACC_W),
                      .STAGES(STAGES), .A_SIGNED(1), .B_SIGNED(1))
      u_dut_s (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(bus_s));

   fracnet_mac_pipe #(.LANES(LANES), .A_W(A_W), .B_W(B_W), .ACC_W(NW),
                      .STAGES(STAGES), .A_SIGNED(0), .B_SIGNED(0))
      u_dut_w (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(bus_w));

   int                     n_tests = 0;
   int                     n_fail  = 0;
   int                     n_out   = 0;
   bit                     bp_mode = 1'b0;
   bit                     prev_stall = 1'b0;
   logic [LANES*ACC_W-1:0] prev_acc = '0;
   sb_t                    sb_q [$];
   vec_t                   tbl [NROWS];

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input int a, input int b, input bit f, input bit l, input int e);
      vec_t r;
      for (int i = 0; i < LANES; i++) begin
         r.a[i*A_W +: A_W]     = A_W'(a);
         r.b[i*B_W +: B_W]     = B_W'(b);
         r.exp[i*ACC_W +: ACC_W] = ACC_W'(e);
      end
      r.first = f;
      r.last  = l;
      return r;
   endfunction

   // One clock cycle on the main instance: drive, then sample 1 time unit later.
   task automatic step(input logic v, input vec_t r, input bit chk_lat, output bit accepted);
      sb_t s;
      @(negedge ap_clk);
      bus.in_valid  = v;
      bus.in_a      = r.a;
      bus.in_b      = r.b;
      bus.in_first  = r.first;
      bus.in_last   = r.last;
      bus.out_ready = bp_mode ? (((cyc / 2) % 2) == 0) : 1'b1;
      #1;
      if (prev_stall) begin
         check("hold_valid", 128'(bus.out_valid), 128'(1));
         check("hold_acc", 128'(bus.out_acc), 128'(prev_acc));
      end
      check("in_ready", 128'(bus.in_ready), 128'(!(bus.out_valid && !bus.out_ready)));
      if (bus.out_valid && bus.out_ready) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL unexpected_out: got %0h expected no result", bus.out_acc);
         end else begin
            s = sb_q.pop_front();
            n_out++;
            $display("[TB] result %0d acc=%h exp=%h", n_out, bus.out_acc, s.exp);
            check("result", 128'(bus.out_acc), 128'(s.exp));
            if (s.lat) check("latency", 128'(cyc - s.t), 128'(STAGES + 1));
         end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_acc   = bus.out_acc;
      accepted   = v && bus.in_ready;
      if (accepted && r.last) sb_q.push_back('{exp: r.exp, t: cyc, lat: chk_lat});
   endtask

   task automatic idle(input int n);
      bit dummy;
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, dummy);
   endtask

   task automatic send(input vec_t r, input bit chk_lat);
      bit acc;
      int k;
      k = 0;
      acc = 1'b0;
      while (!acc && k < 50) begin
         step(1'b1, r, chk_lat, acc);
         k++;
      end
      check("send_accepted", 128'(acc), 128'(1));
   endtask

   task automatic drain(input string nm);
      int k;
      k = 0;
      while (sb_q.size() != 0 && k < 200) begin
         idle(1);
         k++;
      end
      check({nm, "_drain"}, 128'(sb_q.size()), 128'(0));
      idle(4);
   endtask

   initial begin
      int  base_out;
      int  k;
      bit  found;
      vec_t r;

      bus.in_valid = 0; bus.in_a = '0; bus.in_b = '0; bus.in_first = 0; bus.in_last = 0; bus.out_ready = 1;
      bus_s.in_valid = 0; bus_s.in_a = '0; bus_s.in_b = '0; bus_s.in_first = 0; bus_s.in_last = 0; bus_s.out_ready = 1;
      bus_w.in_valid = 0; bus_w.in_a = '0; bus_w.in_b = '0; bus_w.in_first = 0; bus_w.in_last = 0; bus_w.out_ready = 1;

      // Reset values
      repeat (2) @(negedge ap_clk);
      #1;
      check("rst_out_valid", 128'(bus.out_valid), 128'(0));
      check("rst_out_acc", 128'(bus.out_acc), 128'(0));
      check("rst_in_ready", 128'(bus.in_ready), 128'(1));
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      idle(2);

      // Beat table
      tbl[0]  = mk(255, 2047, 1, 1, 255 * 2047);
      tbl[1]  = mk(3, 5, 1, 0, 0);
      tbl[2]  = mk(3, 5, 0, 0, 0);
      tbl[3]  = mk(3, 5, 0, 0, 0);
      tbl[4]  = mk(3, 5, 0, 1, 4 * 3 * 5);
      for (int i = 1; i <= 4; i++) tbl[i].a[2*A_W +: A_W] = '0;
      tbl[4].exp[2*ACC_W +: ACC_W] = '0;
      tbl[5]  = mk(0, 0, 1, 1, 0);
      for (int i = 0; i < LANES; i++) begin
         tbl[5].a[i*A_W +: A_W]       = A_W'(i + 1);
         tbl[5].b[i*B_W +: B_W]       = B_W'(10 * (i + 1));
         tbl[5].exp[i*ACC_W +: ACC_W] = ACC_W'((i + 1) * 10 * (i + 1));
      end
      tbl[6]  = mk(7, 9, 0, 1, 63);           // no first: follows a last
      tbl[7]  = mk(1, 1, 1, 0, 0);
      tbl[8]  = mk(2, 2, 0, 0, 0);
      tbl[9]  = mk(2, 3, 1, 0, 0);            // first mid-group drops 1+4
      tbl[10] = mk(1, 4, 0, 1, 6 + 4);
      tbl[11] = mk(0, 2047, 1, 1, 0);
      tbl[12] = mk(255, 2047, 1, 0, 0);
      tbl[13] = mk(255, 2047, 0, 1, 2 * 255 * 2047);

      base_out = n_out;
      for (int i = 0; i < NROWS; i++) send(tbl[i], i == 0);
      drain("table");
      check("group_count", 128'(n_out - base_out), 128'(7));

      // Backpressure: 10 single-beat groups, out_ready toggling every 2 cycles
      bp_mode  = 1'b1;
      base_out = n_out;
      for (int g = 0; g < 10; g++) begin
         r = mk(0, 0, 1, 1, 0);
         for (int i = 0; i < LANES; i++) begin
            int av, bv;
            av = int'($urandom_range(255));
            bv = int'($urandom_range(2047));
            r.a[i*A_W +: A_W]       = A_W'(av);
            r.b[i*B_W +: B_W]       = B_W'(bv);
            r.exp[i*ACC_W +: ACC_W] = ACC_W'(av * bv);
         end
         send(r, 1'b0);
      end
      drain("backpressure");
      bp_mode = 1'b0;
      idle(2);
      check("bp_count", 128'(n_out - base_out), 128'(10));

      // Reset mid-group drops partial sums and restarts group state
      send(mk(9, 9, 1, 0, 0), 1'b0);
      send(mk(9, 9, 0, 0, 0), 1'b0);
      idle(5);
      @(negedge ap_clk);
      #2 ap_rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 128'(bus.out_valid), 128'(0));
      check("midrst_out_acc", 128'(bus.out_acc), 128'(0));
      idle(2);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      base_out = n_out;
      send(mk(1, 1, 0, 1, 1), 1'b1);         // first beat after reset, no first flag
      send(mk(1, 1, 1, 1, 1), 1'b0);
      drain("reset");
      check("reset_count", 128'(n_out - base_out), 128'(2));

      // Signed instance: -128 * 1023
      @(negedge ap_clk);
      bus_s.in_valid = 1; bus_s.in_first = 1; bus_s.in_last = 1;
      bus_s.in_a = {LANES{8'h80}}; bus_s.in_b = {LANES{11'h3FF}};
      @(negedge ap_clk);
      bus_s.in_valid = 0;
      found = 1'b0; k = 0;
      while (!found && k < 20) begin
         @(negedge ap_clk); #1;
         if (bus_s.out_valid) found = 1'b1;
         k++;
      end
      check("signed_seen", 128'(found), 128'(1));
      r.exp = '0;
      for (int i = 0; i < LANES; i++) r.exp[i*ACC_W +: ACC_W] = ACC_W'(-128 * 1023);
      $display("[TB] signed acc=%h exp=%h", bus_s.out_acc, r.exp);
      check("signed_acc", 128'(bus_s.out_acc), 128'(r.exp));
      @(negedge ap_clk); #1;
      check("signed_once", 128'(bus_s.out_valid), 128'(0));

      // Narrow accumulator: three max products overflow 20 bits
      @(negedge ap_clk);
      bus_w.in_valid = 1; bus_w.in_first = 1; bus_w.in_last = 0;
      bus_w.in_a = {LANES{8'd255}}; bus_w.in_b = {LANES{11'd2047}};
      @(negedge ap_clk);
      bus_w.in_first = 0;
      @(negedge ap_clk);
      bus_w.in_last = 1;
      @(negedge ap_clk);
      bus_w.in_valid = 0; bus_w.in_last = 0;
      found = 1'b0; k = 0;
      while (!found && k < 20) begin
         @(negedge ap_clk); #1;
         if (bus_w.out_valid) found = 1'b1;
         k++;
      end
      check("narrow_seen", 128'(found), 128'(1));
      r.exp = '0;
      for (int i = 0; i < LANES; i++) begin
`ifdef FRACNET_MAC_SAT_EN
         r.exp[i*NW +: NW] = NW'((1 << NW) - 1);
`else
         r.exp[i*NW +: NW] = NW'((3 * 255 * 2047) % (1 << NW));
`endif
      end
      $display("[TB] narrow acc=%h exp=%h", bus_w.out_acc, r.exp[LANES*NW-1:0]);
      check("narrow_acc", 128'(bus_w.out_acc), 128'(r.exp[LANES*NW-1:0]));
      @(negedge ap_clk); #1;
      check("narrow_once", 128'(bus_w.out_valid), 128'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
